// File: rtl/spi_master.sv
// SPI-style master: header byte, optional CFG payload or turnaround + 9-bit
// read, then a one-clock gap. LSB first throughout; suspend stalls bit flow.
module spi_master #(
  parameter logic [7:0]  START_HDR = 8'h01,
  parameter logic [7:0]  CFG_HDR   = 8'h02,
  parameter logic [7:0]  READ_HDR  = 8'h03,
  parameter int unsigned TURN_CYC  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       frame,
  inout  wire logic  serial,
  input  logic       suspend,
  output logic       rd_valid,
  output logic [8:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, HDR, CFG, TURN, RDATA, GAP} state_t;
  typedef enum logic [1:0] {OP_START, OP_CFG, OP_READ, OP_RAW} op_t;

  localparam logic [3:0] TURN_LAST = 4'(TURN_CYC - 1);

  state_t     state, state_n;
  op_t        op_q, op_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] data_q, data_n;
  logic [6:0] sh, sh_n;        // bits still to be presented after the current one
  logic       sdo, sdo_n;
  logic       serial_oe, oe_n;
  logic       frame_n;
  logic [8:0] rd_n;
  logic       rdv_n;
  logic       ready_n;
  logic [7:0] hdr_sel;

  assign serial = serial_oe ? sdo : 1'bz;
  assign busy   = (state != IDLE);

  // Header byte chosen from the incoming op
  always_comb begin
    case (cmd_op)
      2'd0:    hdr_sel = START_HDR;
      2'd1:    hdr_sel = CFG_HDR;
      2'd2:    hdr_sel = READ_HDR;
      default: hdr_sel = cmd_data;
    endcase
  end

  // Next-state and next registered-output logic
  always_comb begin
    state_n = state;
    op_n    = op_q;
    cnt_n   = cnt;
    data_n  = data_q;
    sh_n    = sh;
    sdo_n   = sdo;
    oe_n    = serial_oe;
    frame_n = frame;
    rd_n    = rd_data;
    rdv_n   = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_n    = op_t'(cmd_op);
          data_n  = cmd_data;
          sh_n    = hdr_sel[7:1];
          sdo_n   = hdr_sel[0];
          oe_n    = 1'b1;
          frame_n = 1'b1;
          cnt_n   = '0;
          state_n = HDR;
        end
      end
      HDR: begin
        if (!suspend) begin
          if (cnt == 4'd7) begin
            cnt_n = '0;
            case (op_q)
              OP_CFG: begin
                state_n = CFG;
                sh_n    = data_q[7:1];
                sdo_n   = data_q[0];
              end
              OP_READ: begin
                state_n = TURN;
                oe_n    = 1'b0;
              end
              default: begin
                state_n = GAP;
                oe_n    = 1'b0;
                frame_n = 1'b0;
              end
            endcase
          end else begin
            cnt_n = cnt + 4'd1;
            sdo_n = sh[0];
            sh_n  = {1'b0, sh[6:1]};
          end
        end
      end
      CFG: begin
        if (!suspend) begin
          if (cnt == 4'd7) begin
            cnt_n   = '0;
            state_n = GAP;
            oe_n    = 1'b0;
            frame_n = 1'b0;
          end else begin
            cnt_n = cnt + 4'd1;
            sdo_n = sh[0];
            sh_n  = {1'b0, sh[6:1]};
          end
        end
      end
      TURN: begin
        if (cnt == TURN_LAST) begin
          cnt_n   = '0;
          state_n = RDATA;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      RDATA: begin
        if (!suspend) begin
          // shift in from the top so the first captured bit ends at bit 0
          rd_n = {serial, rd_data[8:1]};
          if (cnt == 4'd8) begin
            rdv_n   = 1'b1;
            frame_n = 1'b0;
            cnt_n   = '0;
            state_n = GAP;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      GAP: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    ready_n = (state_n == IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_START;
      cnt       <= '0;
      data_q    <= '0;
      sh        <= '0;
      sdo       <= 1'b0;
      serial_oe <= 1'b0;
      frame     <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      cnt       <= cnt_n;
      data_q    <= data_n;
      sh        <= sh_n;
      sdo       <= sdo_n;
      serial_oe <= oe_n;
      frame     <= frame_n;
      rd_data   <= rd_n;
      rd_valid  <= rdv_n;
      cmd_ready <= ready_n;
    end
  end

endmodule
